// File: rtl/mem_access_unit.sv
// Load/store stage: issues one data-memory transaction per accepted operation
// over a req/gnt/rvalid handshake and returns extended load data to writeback.
module mem_access_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [3:0]            uop_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] store_data_in,
   input  logic [4:0]            rd_in,
   output logic                  mem_req_out,
   output logic                  mem_we_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [3:0]            mem_be_out,
   output logic [DATA_WIDTH-1:0] mem_wdata_out,
   input  logic                  mem_gnt_in,
   input  logic                  mem_rvalid_in,
   input  logic [DATA_WIDTH-1:0] mem_rdata_in,
   output logic                  wb_valid_out,
   output logic [4:0]            wb_rd_out,
   output logic [DATA_WIDTH-1:0] wb_data_out,
   output logic                  done_out,
   output logic                  err_out,
   output logic [ADDR_WIDTH-1:0] err_addr_out
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t                state, next_state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            uop_q;
   logic [DATA_WIDTH-1:0] sdata_q;
   logic [4:0]            rd_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] wb_data_q;
   logic [4:0]            wb_rd_q;
   logic [ADDR_WIDTH-1:0] err_addr_q;

   logic                  illegal, misaligned, bad_op, accept;
   logic [1:0]            off;
   logic [DATA_WIDTH-1:0] shifted, load_data;

   // Decode legality of the operation being offered, before it is registered
   always_comb begin
      case (uop_in)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
         4'b1000, 4'b1001, 4'b1010: illegal = 1'b0;
         default:                   illegal = 1'b1;
      endcase
      misaligned = ((uop_in[1:0] == 2'b01) && addr_in[0]) ||
                   ((uop_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
      bad_op     = illegal || misaligned;
   end

   assign accept = valid_in && (state == S_IDLE);
   assign off    = addr_q[1:0];

   always_comb begin
      shifted   = mem_rdata_in >> {off, 3'b000};
      load_data = mem_rdata_in;
      case (uop_q[2:0])
         3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: load_data = mem_rdata_in;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         uop_q      <= '0;
         sdata_q    <= '0;
         rd_q       <= '0;
         err_q      <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         err_addr_q <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            addr_q  <= addr_in;
            uop_q   <= uop_in;
            sdata_q <= store_data_in;
            rd_q    <= rd_in;
            err_q   <= bad_op;
            if (bad_op)
               err_addr_q <= addr_in;
         end
         if ((state == S_WAIT) && mem_rvalid_in) begin
            wb_data_q <= load_data;
            wb_rd_q   <= rd_q;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (valid_in) next_state = bad_op ? S_RESP : S_REQ;
         S_REQ:  if (mem_gnt_in) next_state = uop_q[3] ? S_RESP : S_WAIT;
         S_WAIT: if (mem_rvalid_in) next_state = S_RESP;
         S_RESP: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Memory-side signals are only driven while the request is outstanding
   always_comb begin
      ready_out     = (state == S_IDLE);
      mem_req_out   = 1'b0;
      mem_we_out    = 1'b0;
      mem_addr_out  = '0;
      mem_be_out    = '0;
      mem_wdata_out = '0;
      if (state == S_REQ) begin
         mem_req_out  = 1'b1;
         mem_we_out   = uop_q[3];
         mem_addr_out = {addr_q[ADDR_WIDTH-1:2], 2'b00};
         case (uop_q[1:0])
            2'b00: begin
               mem_be_out    = 4'b0001 << off;
               mem_wdata_out = {4{sdata_q[7:0]}};
            end
            2'b01: begin
               mem_be_out    = 4'b0011 << off;
               mem_wdata_out = {2{sdata_q[15:0]}};
            end
            default: begin
               mem_be_out    = 4'b1111;
               mem_wdata_out = sdata_q;
            end
         endcase
      end
      done_out     = (state == S_RESP);
      err_out      = (state == S_RESP) && err_q;
      wb_valid_out = (state == S_RESP) && !err_q && !uop_q[3];
   end

   assign wb_data_out  = wb_data_q;
   assign wb_rd_out    = wb_rd_q;
   assign err_addr_out = err_addr_q;

endmodule
